// File: rtl/vga1306_link_pkg.sv
// Shared constants and FSM encoding for the VGA1306 pixel-write link transmitter.
package vga1306_link_pkg;

  localparam int LINK_ADDR_W   = 13;
  localparam int LINK_DATA_W   = 2;
  localparam int FRAME_BYTES   = 1024;
  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } link_state_e;

endpackage

// File: rtl/vga1306_wclk_gen.sv
// Link write-clock divider; freezes while not running and is forced low by clr.
module vga1306_wclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK25MHz,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic wclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc   = run && (div_cnt == DIV_TC);
  assign rise_evt = div_tc && !wclk;
  assign fall_evt = div_tc && wclk;

  always_ff @(posedge CLK25MHz or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      wclk    <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      wclk    <= 1'b0;
    end else if (run) begin
      if (div_tc) begin
        div_cnt <= '0;
        wclk    <= ~wclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga1306_frame_tx.sv
// Streams one SSD1306-format frame out over the VGA1306 write link, MSB first per byte.
//   state    | meaning
//   ST_IDLE  | wclk parked low, waiting for start
//   ST_GAP   | GAP_WCLKS rises with write_en low to reset the receiver address
//   ST_LOAD  | s_ready high, wclk stalled low until a byte arrives
//   ST_SHIFT | eight link writes of the held byte
module vga1306_frame_tx #(
  parameter int CLK_DIV     = 2,
  parameter int GAP_WCLKS   = 2,
  parameter int FRAME_BYTES = vga1306_link_pkg::FRAME_BYTES
) (
  input  logic                                      CLK25MHz,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      invert,
  input  logic [vga1306_link_pkg::BITS_PER_BYTE-1:0] s_data,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  output logic                                      wclk,
  output logic                                      write_en,
  output logic [vga1306_link_pkg::LINK_DATA_W-1:0]  din,
  output logic                                      cs,
  output logic                                      busy,
  output logic                                      frame_done
);

  import vga1306_link_pkg::*;

  localparam int BIT_W  = $clog2(BITS_PER_BYTE);
  localparam int BYTE_W = LINK_ADDR_W - BIT_W;
  localparam int GAP_W  = $clog2(GAP_WCLKS + 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0]  GAP_TC    = GAP_W'(GAP_WCLKS);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(BITS_PER_BYTE - 1);

  link_state_e              state;
  logic [BYTE_W-1:0]        byte_cnt;
  logic [GAP_W-1:0]         gap_cnt;
  logic [BIT_W-1:0]         bit_idx;
  logic [BIT_W-1:0]         bit_nxt;
  logic [BITS_PER_BYTE-1:0] shift_reg;
  logic                     rise_evt;
  logic                     fall_evt;

  assign s_ready = (state == ST_LOAD);
  assign bit_nxt = bit_idx - 1'b1;

  vga1306_wclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_wclk_gen (
    .CLK25MHz (CLK25MHz),
    .reset    (reset),
    .clr      (state == ST_IDLE),
    .run      ((state == ST_GAP) || (state == ST_SHIFT)),
    .wclk     (wclk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  always_ff @(posedge CLK25MHz or posedge reset) begin
    if (reset) cs <= 1'b0;
    else       cs <= invert;
  end

  always_ff @(posedge CLK25MHz or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      write_en   <= 1'b0;
      din        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        // a start landing on the frame_done cycle is dropped so frames never chain
        ST_IDLE: begin
          if (start && !frame_done) begin
            state    <= ST_GAP;
            busy     <= 1'b1;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            write_en <= 1'b0;
            din      <= '0;
          end
        end
        // leave on the fall after the last gap rise so LOAD can stall with wclk low
        ST_GAP: begin
          if (rise_evt) gap_cnt <= gap_cnt + 1'b1;
          if (fall_evt && (gap_cnt == GAP_TC)) state <= ST_LOAD;
        end
        // wclk is already low here, so bit 7 is driven at accept and still gets CLK_DIV cycles of setup
        ST_LOAD: begin
          if (s_valid) begin
            shift_reg <= s_data;
            bit_idx   <= TOP_BIT;
            write_en  <= 1'b1;
            din       <= LINK_DATA_W'(s_data[BITS_PER_BYTE-1]);
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (fall_evt) begin
            if (bit_idx != '0) begin
              bit_idx <= bit_nxt;
              din     <= LINK_DATA_W'(shift_reg[bit_nxt]);
            end else if (byte_cnt == LAST_BYTE) begin
              write_en   <= 1'b0;
              din        <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
